// File: rtl/pu_or1k_pfpu32_addsub_rnd_if.sv
// pu_or1k_pfpu32_addsub_rnd_if
// Purpose: the add_* bundle passed from the pfpu32 add/sub front end to the
//          rounding/packing back end.
// Signals:
//   add_rdy_i        bundle valid
//   add_sign_i       result sign
//   add_sub_0_i      effective subtraction with exact zero result
//   add_shl_i        left shift amount for normalisation
//   add_exp10shl_i   exponent to use if the left shift is applied
//   add_exp10sh0_i   exponent to use if no shift is applied
//   add_fract28_i    [27] carry, [26] hidden, [25:3] fraction, [2] g, [1] r, [0] sticky
//   add_inv_i, add_inf_i, add_snan_i, add_qnan_i, add_anan_sign_i  special-case flags
// Modports: master (front end drives), slave (rounding stage consumes).
interface pu_or1k_pfpu32_addsub_rnd_if;
  logic        add_rdy_i;
  logic        add_sign_i;
  logic        add_sub_0_i;
  logic [4:0]  add_shl_i;
  logic [9:0]  add_exp10shl_i;
  logic [9:0]  add_exp10sh0_i;
  logic [27:0] add_fract28_i;
  logic        add_inv_i;
  logic        add_inf_i;
  logic        add_snan_i;
  logic        add_qnan_i;
  logic        add_anan_sign_i;

  modport master (
    output add_rdy_i, add_sign_i, add_sub_0_i, add_shl_i, add_exp10shl_i,
           add_exp10sh0_i, add_fract28_i, add_inv_i, add_inf_i, add_snan_i,
           add_qnan_i, add_anan_sign_i
  );

  modport slave (
    input  add_rdy_i, add_sign_i, add_sub_0_i, add_shl_i, add_exp10shl_i,
           add_exp10sh0_i, add_fract28_i, add_inv_i, add_inf_i, add_snan_i,
           add_qnan_i, add_anan_sign_i
  );
endinterface

// File: rtl/pu_or1k_pfpu32_addsub_rnd.sv
// pu_or1k_pfpu32_addsub_rnd
// Purpose: normalise, round and pack the 28-bit add/sub sum into an IEEE-754
//          single, with OR1K rounding modes, special cases and exception flags.
//          Two pipeline stages (A: align, B: round/pack) advance on adv_i.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   flush_i, adv_i    pipe flush, pipe advance
//   rmode_i           00 RNE, 01 RTZ, 10 +inf, 11 -inf
//   add               add_* bundle (slave modport)
//   rdy_o, result_o   result valid, packed result
//   inv_o, ovf_o, unf_o, inx_o, zero_o   exception / status flags
// Configuration macro: PFPU32_DENORM_FLUSH_EN
//   defined   -> nonzero tiny results flush to signed zero (unf, inx, zero set)
//   undefined -> gradual underflow
module pu_or1k_pfpu32_addsub_rnd (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush_i,
  input  logic                              adv_i,
  input  logic [1:0]                        rmode_i,
  pu_or1k_pfpu32_addsub_rnd_if.slave        add,
  output logic                              rdy_o,
  output logic [31:0]                       result_o,
  output logic                              inv_o,
  output logic                              ovf_o,
  output logic                              unf_o,
  output logic                              inx_o,
  output logic                              zero_o
);

  // ---------------- stage A: alignment ----------------
  logic [26:0] w_fract27;
  logic [9:0]  w_exp10;
  logic        w_tiny;

  always_comb begin
    w_fract27 = add.add_fract28_i[26:0];
    w_exp10   = add.add_exp10sh0_i;
    if (add.add_fract28_i[27]) begin
      // carry: shift right one, fold the dropped bit into sticky
      w_fract27 = {add.add_fract28_i[27:2], add.add_fract28_i[1] | add.add_fract28_i[0]};
      w_exp10   = add.add_exp10sh0_i + 10'd1;
    end else if (add.add_shl_i != 5'd0) begin
      w_fract27 = add.add_fract28_i[26:0] << add.add_shl_i;
      w_exp10   = add.add_exp10shl_i;
    end
  end

  assign w_tiny = ~w_fract27[26];

  logic        r_a_rdy;
  logic        r_a_sign, r_a_sub0, r_a_tiny;
  logic [1:0]  r_a_rmode;
  logic [26:0] r_a_fract;
  logic [9:0]  r_a_exp;
  logic        r_a_inv, r_a_inf, r_a_snan, r_a_qnan, r_a_anan_sign;

  always_ff @(posedge clk) begin
    if (rst || flush_i) r_a_rdy <= 1'b0;
    else if (adv_i)     r_a_rdy <= add.add_rdy_i;
  end

  always_ff @(posedge clk) begin
    if (adv_i) begin
      r_a_sign      <= add.add_sign_i;
      r_a_sub0      <= add.add_sub_0_i;
      r_a_rmode     <= rmode_i;
      r_a_fract     <= w_fract27;
      // a denormal encodes exponent field 0
      r_a_exp       <= w_tiny ? 10'd0 : w_exp10;
      r_a_tiny      <= w_tiny;
      r_a_inv       <= add.add_inv_i;
      r_a_inf       <= add.add_inf_i;
      r_a_snan      <= add.add_snan_i;
      r_a_qnan      <= add.add_qnan_i;
      r_a_anan_sign <= add.add_anan_sign_i;
    end
  end

  // ---------------- stage B: rounding and packing ----------------
  logic        w_lsb, w_g, w_rs, w_rnd_up, w_inexact, w_maxfin;
  logic [24:0] w_m25;
  logic [9:0]  w_exp_r;
  logic        w_ovf, w_zero;
  logic [31:0] w_res;
  logic        w_inv_f, w_ovf_f, w_unf_f, w_inx_f, w_zero_f;

  assign w_lsb     = r_a_fract[3];
  assign w_g       = r_a_fract[2];
  assign w_rs      = r_a_fract[1] | r_a_fract[0];
  assign w_inexact = w_g | w_rs;

  always_comb begin
    case (r_a_rmode)
      2'b00:   w_rnd_up = w_g & (w_rs | w_lsb);
      2'b01:   w_rnd_up = 1'b0;
      2'b10:   w_rnd_up = ~r_a_sign & w_inexact;
      default: w_rnd_up = r_a_sign & w_inexact;
    endcase
  end

  // mantissa carry-out gives exactly 1.0 (low bits wrap to 0); a tiny value
  // rounding into the hidden bit becomes the smallest normal, exponent 1
  assign w_m25   = {1'b0, r_a_fract[26:3]} + {24'd0, w_rnd_up};
  assign w_exp_r = r_a_exp + {9'd0, w_m25[24]} + {9'd0, r_a_tiny & w_m25[23]};
  assign w_ovf   = ~w_exp_r[9] & (w_exp_r[8:0] >= 9'd255);
  assign w_zero  = r_a_sub0 | (r_a_fract == 27'd0);
  assign w_maxfin = (r_a_rmode == 2'b01) | ((r_a_rmode == 2'b10) & r_a_sign) |
                    ((r_a_rmode == 2'b11) & ~r_a_sign);

  always_comb begin
    w_res    = {r_a_sign, w_exp_r[7:0], w_m25[22:0]};
    w_inv_f  = 1'b0;
    w_ovf_f  = 1'b0;
    w_unf_f  = r_a_tiny & w_inexact;
    w_inx_f  = w_inexact;
    w_zero_f = 1'b0;
    if (r_a_inv || r_a_snan || r_a_qnan) begin
      w_res   = {(r_a_inv ? 1'b0 : r_a_anan_sign), 31'h7FC00000};
      w_inv_f = r_a_inv | r_a_snan;
      w_unf_f = 1'b0;
      w_inx_f = 1'b0;
    end else if (r_a_inf) begin
      w_res   = {r_a_sign, 8'hFF, 23'h0};
      w_unf_f = 1'b0;
      w_inx_f = 1'b0;
    end else if (w_zero) begin
      w_res    = {((r_a_rmode == 2'b11) ? 1'b1 : r_a_sign), 31'h0};
      w_unf_f  = 1'b0;
      w_inx_f  = 1'b0;
      w_zero_f = 1'b1;
    end else if (w_ovf) begin
      w_res   = w_maxfin ? {r_a_sign, 31'h7F7FFFFF} : {r_a_sign, 8'hFF, 23'h0};
      w_ovf_f = 1'b1;
      w_unf_f = 1'b0;
      w_inx_f = 1'b1;
`ifdef PFPU32_DENORM_FLUSH_EN
    end else if (r_a_tiny) begin
      w_res    = {r_a_sign, 31'h0};
      w_unf_f  = 1'b1;
      w_inx_f  = 1'b1;
      w_zero_f = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      rdy_o    <= 1'b0;
      result_o <= 32'h0;
      inv_o    <= 1'b0;
      ovf_o    <= 1'b0;
      unf_o    <= 1'b0;
      inx_o    <= 1'b0;
      zero_o   <= 1'b0;
    end else if (adv_i) begin
      rdy_o    <= r_a_rdy;
      result_o <= w_res;
      inv_o    <= w_inv_f;
      ovf_o    <= w_ovf_f;
      unf_o    <= w_unf_f;
      inx_o    <= w_inx_f;
      zero_o   <= w_zero_f;
    end
  end

endmodule

// File: tb/tb_pu_or1k_pfpu32_addsub_rnd.sv
module tb_pu_or1k_pfpu32_addsub_rnd;
  logic        clk = 1'b0;
  logic        rst, flush_i, adv_i;
  logic [1:0]  rmode_i;
  logic        rdy_o, inv_o, ovf_o, unf_o, inx_o, zero_o;
  logic [31:0] result_o;
  int          n_pass = 0;
  int          n_total = 0;

  pu_or1k_pfpu32_addsub_rnd_if u_if ();

  pu_or1k_pfpu32_addsub_rnd dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .adv_i(adv_i), .rmode_i(rmode_i),
    .add(u_if.slave), .rdy_o(rdy_o), .result_o(result_o), .inv_o(inv_o),
    .ovf_o(ovf_o), .unf_o(unf_o), .inx_o(inx_o), .zero_o(zero_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // flags packed as {inv, ovf, unf, inx, zero}
  task automatic chk_res(input string tag, input logic [31:0] res, input logic [4:0] flags);
    chk({tag, ".rdy"}, {31'd0, rdy_o}, 32'd1);
    chk({tag, ".res"}, result_o, res);
    chk({tag, ".flg"}, {27'd0, inv_o, ovf_o, unf_o, inx_o, zero_o}, {27'd0, flags});
  endtask

  task automatic clr(input logic [27:0] fract, input logic [9:0] exp0, input logic [1:0] rm);
    u_if.add_rdy_i       = 1'b1;
    u_if.add_sign_i      = 1'b0;
    u_if.add_sub_0_i     = 1'b0;
    u_if.add_shl_i       = 5'd0;
    u_if.add_exp10shl_i  = 10'd0;
    u_if.add_exp10sh0_i  = exp0;
    u_if.add_fract28_i   = fract;
    u_if.add_inv_i       = 1'b0;
    u_if.add_inf_i       = 1'b0;
    u_if.add_snan_i      = 1'b0;
    u_if.add_qnan_i      = 1'b0;
    u_if.add_anan_sign_i = 1'b0;
    rmode_i              = rm;
  endtask

  task automatic go();
    adv_i = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; flush_i = 1'b0; adv_i = 1'b0;
    clr(28'h0, 10'd0, 2'b00);
    u_if.add_rdy_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.rdy", {31'd0, rdy_o}, 32'd0);
    chk("reset.res", result_o, 32'h0);
    chk("reset.flg", {27'd0, inv_o, ovf_o, unf_o, inx_o, zero_o}, 32'd0);
    rst = 1'b0;

    clr(28'h4000000, 10'd127, 2'b00); go(); chk_res("one", 32'h3F800000, 5'b00000);
    clr(28'h8000000, 10'd127, 2'b00); go(); chk_res("carry", 32'h40000000, 5'b00000);
    clr(28'h4000004, 10'd127, 2'b00); go(); chk_res("rne_tie_even", 32'h3F800000, 5'b00010);
    clr(28'h400000C, 10'd127, 2'b00); go(); chk_res("rne_tie_odd", 32'h3F800002, 5'b00010);
    clr(28'h7FFFFFC, 10'd127, 2'b00); go(); chk_res("mant_carry", 32'h40000000, 5'b00010);
    clr(28'h8000000, 10'd254, 2'b00); go(); chk_res("ovf_rne", 32'h7F800000, 5'b01010);
    clr(28'h8000000, 10'd254, 2'b01); go(); chk_res("ovf_rtz", 32'h7F7FFFFF, 5'b01010);
    clr(28'h8000000, 10'd254, 2'b01); u_if.add_sign_i = 1'b1; go();
    chk_res("ovf_rtz_neg", 32'hFF7FFFFF, 5'b01010);
    clr(28'h8000000, 10'd254, 2'b11); go(); chk_res("ovf_minf_pos", 32'h7F7FFFFF, 5'b01010);
    clr(28'h8000000, 10'd254, 2'b11); u_if.add_sign_i = 1'b1; go();
    chk_res("ovf_minf_neg", 32'hFF800000, 5'b01010);
    clr(28'h0200000, 10'd0, 2'b00); u_if.add_shl_i = 5'd5; u_if.add_exp10shl_i = 10'd100; go();
    chk_res("shl", 32'h32000000, 5'b00000);
    clr(28'h4000001, 10'd127, 2'b10); go(); chk_res("pinf_up", 32'h3F800001, 5'b00010);
    clr(28'h4000001, 10'd127, 2'b10); u_if.add_sign_i = 1'b1; go();
    chk_res("pinf_neg", 32'hBF800000, 5'b00010);
    clr(28'h4000001, 10'd127, 2'b11); u_if.add_sign_i = 1'b1; go();
    chk_res("minf_neg_up", 32'hBF800001, 5'b00010);
    clr(28'h0000010, 10'd3, 2'b00); go(); chk_res("denorm_exact", 32'h00000002, 5'b00000);
`ifdef PFPU32_DENORM_FLUSH_EN
    clr(28'h0000014, 10'd3, 2'b00); go(); chk_res("denorm_inx", 32'h00000000, 5'b00111);
    clr(28'h3FFFFFC, 10'd3, 2'b00); go(); chk_res("denorm_to_norm", 32'h00000000, 5'b00111);
`else
    clr(28'h0000014, 10'd3, 2'b00); go(); chk_res("denorm_inx", 32'h00000002, 5'b00110);
    clr(28'h3FFFFFC, 10'd3, 2'b00); go(); chk_res("denorm_to_norm", 32'h00800000, 5'b00110);
`endif
    clr(28'h4000000, 10'd127, 2'b11); u_if.add_sub_0_i = 1'b1; go();
    chk_res("zero_minf", 32'h80000000, 5'b00001);
    clr(28'h0000000, 10'd127, 2'b00); go(); chk_res("zero_rne", 32'h00000000, 5'b00001);
    clr(28'h4000000, 10'd127, 2'b00); u_if.add_snan_i = 1'b1; go();
    chk_res("snan", 32'h7FC00000, 5'b10000);
    clr(28'h4000000, 10'd127, 2'b00); u_if.add_qnan_i = 1'b1; u_if.add_anan_sign_i = 1'b1; go();
    chk_res("qnan", 32'hFFC00000, 5'b00000);
    clr(28'h4000000, 10'd127, 2'b00); u_if.add_inv_i = 1'b1; u_if.add_anan_sign_i = 1'b1;
    u_if.add_inf_i = 1'b1; go();
    chk_res("inv", 32'h7FC00000, 5'b10000);
    clr(28'h4000000, 10'd127, 2'b00); u_if.add_inf_i = 1'b1; u_if.add_sign_i = 1'b1; go();
    chk_res("inf", 32'hFF800000, 5'b00000);

    // stall: last result (-inf) must hold while adv_i is low
    clr(28'h8000000, 10'd127, 2'b00);
    adv_i = 1'b1; @(posedge clk); #1;
    adv_i = 1'b0;
    clr(28'h0000000, 10'd0, 2'b01);
    u_if.add_rdy_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_res("stall_hold", 32'hFF800000, 5'b00000);
    adv_i = 1'b1; @(posedge clk); #1;
    chk_res("stall_resume", 32'h40000000, 5'b00000);

    // flush after the first advance
    clr(28'h4000000, 10'd127, 2'b00); go();
    adv_i = 1'b1; @(posedge clk); #1;
    flush_i = 1'b1; @(posedge clk); #1;
    flush_i = 1'b0;
    chk("flush.rdy0", {31'd0, rdy_o}, 32'd0);
    u_if.add_rdy_i = 1'b0;
    @(posedge clk); #1;
    chk("flush.rdy1", {31'd0, rdy_o}, 32'd0);

    // reset wins over adv_i
    clr(28'h4000000, 10'd127, 2'b00); go();
    chk("prerst.rdy", {31'd0, rdy_o}, 32'd1);
    rst = 1'b1; @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_adv.rdy", {31'd0, rdy_o}, 32'd0);
    chk("rst_adv.res", result_o, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
